// File: rtl/fetch_ctrl.sv
// fetch_ctrl: RV32I instruction-fetch sequencer.
// Owns the next-PC register and drives the fetch stage's pc and capture
// enable. It also tracks the PC and valid bit of the instruction that fetch is
// presenting, and handles boot, stall, redirect with squash, and address faults.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS   = 32'h0000_6000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_pc,
  output logic        fetch_en,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        fault,
  output logic [31:0] fault_pc
);

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StFault
  } state_e;

  state_e      r_state, w_state_d;
  logic [31:0] r_pc, w_pc_d;
  logic [31:0] r_if_pc, w_if_pc_d;
  logic        r_if_valid, w_if_valid_d;
  logic        r_fault, w_fault_d;
  logic [31:0] r_fault_pc, w_fault_pc_d;
  logic        w_fetch_en;
  logic        w_pc_legal;
  logic        w_redirect_legal;

  // A PC is legal when word-aligned and inside instruction memory.
  function automatic logic pc_legal(input logic [31:0] pc);
    return (pc[1:0] == 2'b00) && ({2'b00, pc[31:2]} < IMEM_WORDS);
  endfunction

  assign w_pc_legal       = pc_legal(r_pc);
  assign w_redirect_legal = pc_legal(redirect_pc);

  // Next-state and capture-enable decode; redirect outranks stall outranks advance.
  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc;
    w_if_pc_d    = r_if_pc;
    w_if_valid_d = r_if_valid;
    w_fault_d    = r_fault;
    w_fault_pc_d = r_fault_pc;
    w_fetch_en   = 1'b0;

    unique case (r_state)
      StBoot: begin
        // Boot fetch ignores stall and redirect.
        w_fetch_en   = 1'b1;
        w_if_pc_d    = r_pc;
        w_if_valid_d = 1'b1;
        w_pc_d       = r_pc + 32'd4;
        w_state_d    = StRun;
      end

      StRun: begin
        if (redirect) begin
          // Squash whatever fetch currently holds; a simultaneous stall is moot.
          w_if_valid_d = 1'b0;
          if (!w_redirect_legal) begin
            w_state_d    = StFault;
            w_fault_d    = 1'b1;
            w_fault_pc_d = redirect_pc;
          end else begin
            w_pc_d = redirect_pc;
          end
        end else if (stall) begin
          // Hold everything; fetch must not capture.
          w_fetch_en = 1'b0;
        end else if (!w_pc_legal) begin
          // Catches both run-off-end and 32-bit wrap before any fetch issues.
          w_state_d    = StFault;
          w_fault_d    = 1'b1;
          w_fault_pc_d = r_pc;
          w_if_valid_d = 1'b0;
        end else begin
          w_fetch_en   = 1'b1;
          w_if_pc_d    = r_pc;
          w_if_valid_d = 1'b1;
          w_pc_d       = r_pc + 32'd4;
        end
      end

      StFault: begin
        // Terminal until reset.
        w_if_valid_d = 1'b0;
      end

      default: begin
        w_state_d = StFault;
      end
    endcase
  end

  // State registers with synchronous reset that overrides any pending event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StBoot;
      r_pc       <= RESET_VECTOR;
      r_if_pc    <= 32'h0;
      r_if_valid <= 1'b0;
      r_fault    <= 1'b0;
      r_fault_pc <= 32'h0;
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_if_pc    <= w_if_pc_d;
      r_if_valid <= w_if_valid_d;
      r_fault    <= w_fault_d;
      r_fault_pc <= w_fault_pc_d;
    end
  end

  // fetch_pc is purely registered; only fetch_en sees stall/redirect/rst.
  assign fetch_pc = r_pc;
  assign fetch_en = w_fetch_en & ~rst;
  assign if_pc    = r_if_pc;
  assign if_valid = r_if_valid;
  assign fault    = r_fault;
  assign fault_pc = r_fault_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a behavioural reference model predicts the
// registered outputs, pushes them to a queue, and the queue is drained after each
// clock edge; directed constant checks pin down the key test-plan values.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_pc;
  logic        fetch_en;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        fault;
  logic [31:0] fault_pc;

  fetch_ctrl #(
    .RESET_VECTOR(32'h0000_0000),
    .IMEM_WORDS  (32'h0000_6000)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .fetch_pc   (fetch_pc),
    .fetch_en   (fetch_en),
    .if_pc      (if_pc),
    .if_valid   (if_valid),
    .fault      (fault),
    .fault_pc   (fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] fpc;
    logic [31:0] ipc;
    logic        vld;
    logic        flt;
    logic [31:0] fltpc;
  } exp_t;

  exp_t exp_q[$];

  int n_vec;
  int n_err;

  // Reference model state: 0 boot, 1 run, 2 fault.
  int          m_state;
  logic [31:0] m_pc;
  logic [31:0] m_ipc;
  logic        m_vld;
  logic        m_flt;
  logic [31:0] m_fltpc;
  logic        m_known;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic legal(input logic [31:0] a);
    return (a < 32'h0001_8000) && (a % 4 == 0);
  endfunction

  // One clock cycle: drive inputs, check combinational outputs, advance the model,
  // queue the predicted registered outputs, then clock and compare.
  task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    logic exp_en;
    exp_t e;
    exp_t got;
    rst         = r;
    stall       = s;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    if (r) exp_en = 1'b0;
    else if (m_state == 0) exp_en = 1'b1;
    else if (m_state == 1) exp_en = !rd && !s && legal(m_pc);
    else exp_en = 1'b0;
    if (m_known) begin
      check("fetch_en", {31'b0, fetch_en}, {31'b0, exp_en});
      check("fetch_pc_pre", fetch_pc, m_pc);
    end

    if (r) begin
      m_state = 0; m_pc = 32'h0; m_ipc = 32'h0; m_vld = 1'b0;
      m_flt = 1'b0; m_fltpc = 32'h0; m_known = 1'b1;
    end else if (m_state == 0) begin
      m_ipc = m_pc; m_vld = 1'b1; m_pc = m_pc + 32'd4; m_state = 1;
    end else if (m_state == 1) begin
      if (rd) begin
        m_vld = 1'b0;
        if (legal(rpc)) m_pc = rpc;
        else begin m_state = 2; m_flt = 1'b1; m_fltpc = rpc; end
      end else if (!s) begin
        if (legal(m_pc)) begin
          m_ipc = m_pc; m_vld = 1'b1; m_pc = m_pc + 32'd4;
        end else begin
          m_state = 2; m_flt = 1'b1; m_fltpc = m_pc; m_vld = 1'b0;
        end
      end
    end
    e.fpc = m_pc; e.ipc = m_ipc; e.vld = m_vld; e.flt = m_flt; e.fltpc = m_fltpc;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("fetch_pc", fetch_pc, got.fpc);
    check("if_pc", if_pc, got.ipc);
    check("if_valid", {31'b0, if_valid}, {31'b0, got.vld});
    check("fault", {31'b0, fault}, {31'b0, got.flt});
    check("fault_pc", fault_pc, got.fltpc);
  endtask

  initial begin
    n_vec = 0; n_err = 0; m_known = 1'b0; m_state = 0;
    m_pc = 32'h0; m_ipc = 32'h0; m_vld = 1'b0; m_flt = 1'b0; m_fltpc = 32'h0;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    @(posedge clk);
    #1;

    // Boot: reset 3 cycles, then fetch 0,4,8.
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("rst_valid", {31'b0, if_valid}, 32'h0);
    check("rst_pc", fetch_pc, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("boot_ipc", if_pc, 32'h0);
    check("boot_vld", {31'b0, if_valid}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("run_ipc8", if_pc, 32'h8);

    // Stall 3 cycles while if_pc=8.
    repeat (3) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      check("stall_fpc", fetch_pc, 32'hC);
      check("stall_ipc", if_pc, 32'h8);
      check("stall_en", {31'b0, fetch_en}, 32'h0);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("resume_ipc", if_pc, 32'hC);

    // Redirect with simultaneous stall.
    step(1'b0, 1'b1, 1'b1, 32'h100);
    check("redir_vld", {31'b0, if_valid}, 32'h0);
    check("redir_fpc", fetch_pc, 32'h100);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("redir_ipc", if_pc, 32'h100);
    repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);

    // Run off the end of instruction memory.
    step(1'b0, 1'b0, 1'b1, 32'h17FFC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("end_ipc", if_pc, 32'h17FFC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("end_fault", {31'b0, fault}, 32'h1);
    check("end_fpc", fault_pc, 32'h18000);
    repeat (2) step(1'b0, 1'b0, 1'b1, 32'h0);

    // Reset mid-fault, reboot, then misaligned redirect.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("rst_fault", {31'b0, fault}, 32'h0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h102);
    check("mis_fault", fault_pc, 32'h102);
    repeat (3) step(1'b0, 1'b0, 1'b1, 32'h0);
    check("mis_hold", fault_pc, 32'h102);
    check("mis_vld", {31'b0, if_valid}, 32'h0);

    // Reset mid-stall.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("rst_stall_vld", {31'b0, if_valid}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("reboot_ipc", if_pc, 32'h0);

    // Random traffic: mostly legal redirects, some bad ones, rare resets.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      logic        r;
      tgt = {$urandom_range(32'h5FF0, 32'h6000), 2'b00};
      if ($urandom_range(0, 3) == 0) tgt = {$urandom_range(0, 32'h40), 2'b00};
      if ($urandom_range(0, 19) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 29) == 0) tgt = 32'hFFFF_FFFC;
      r = ($urandom_range(0, 39) == 0);
      step(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
